parking_lane_arbiter: RTL and testbench
=======================================

// Module: parking_lane_arbiter
// PURPOSE
//  - Shares one PIN checker and one gate sequencer between two entry lanes (lane0, lane1) of the parking lot.
//  - Grants one lane at a time, round-robin, and forwards that lane's PIN to the checker.
//  - Opens the granted lane's gate on a good PIN; counts strikes per lane and blocks a lane after MAX_TRIES bad PINs.
//  - Tracks lot occupancy; refuses grants while the lot is full.
// PARAMETERS
//  CAPACITY   16   max vehicles in lot
//  CNT_W      5    occupancy width, >= clog2(CAPACITY+1)
//  MAX_TRIES  3    consecutive bad PINs before a lane blocks
//  TIMEOUT    255  grant watchdog cycles (used only with PARKING_GRANT_TIMEOUT_EN)
// PORTS
//  clk           in   1      clock, rising edge
//  rst_n         in   1      async active-low reset
//  laneReq       in   2      level; vehicle waiting at lane i
//  lanePin0      in   8      PIN presented at lane0
//  lanePin1      in   8      PIN presented at lane1
//  laneEnter     in   2      1-cycle pulse; vehicle passed lane i gate
//  exitPulse     in   1      1-cycle pulse; vehicle left lot
//  clearBlock    in   1      1-cycle pulse; operator clears both lanes' blocks and strikes
//  chkValid      out  1      PIN check request to shared checker
//  chkPin        out  8      PIN under check, stable while chkValid
//  chkDone       in   1      1-cycle pulse; check result valid
//  chkOk         in   1      PIN correct, sampled with chkDone
//  laneGnt       out  2      one-hot owner of checker/gate, 0 when idle
//  gateOpen      out  2      gate of lane i open
//  laneBlocked   out  2      lane i blocked (wrong-PIN alarm)
//  lotFull       out  1      occupancy == CAPACITY
//  occupancy     out  CNT_W  vehicles in lot
//  grantTimeout  out  1      1-cycle pulse; watchdog expiry
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, strikes 0, lastServed=1 (lane0 wins first tie).
//  FSM (all outputs registered):
//  - IDLE: eligible = laneReq & ~laneBlocked.
//    - If !lotFull and eligible != 0, pick a lane; both eligible -> the lane != lastServed.
//    - Next cycle: laneGnt set, chkPin captured from the selected lane, chkValid=1, state CHECK.
//    - chkDone in IDLE is ignored.
//  - CHECK: chkValid/chkPin held until chkDone.
//    - chkDone&chkOk -> OPEN; clear that lane's strikes.
//    - chkDone&!chkOk -> strikes+1; if strikes reach MAX_TRIES, set laneBlocked[g]; -> IDLE.
//    - laneReq[g] drops before chkDone -> abort to IDLE; a later chkDone is ignored.
//  - OPEN: gateOpen[g]=1.
//    - laneEnter[g] -> occupancy+1, -> IDLE.
//    - laneReq[g] drops with no enter -> IDLE, no count.
//  - Leaving CHECK/OPEN: laneGnt=0, chkValid=0, gateOpen=0; lastServed=g.
//    - Earliest regrant is the cycle after returning to IDLE (IDLE lasts >= 1 cycle).
//  Counting:
//  - laneEnter for a non-granted lane is ignored.
//  - exitPulse with occupancy 0 is ignored (no wrap).
//  - Enter and exit in the same cycle -> net 0.
//  - Occupancy never exceeds CAPACITY.
//  - lotFull is combinational from occupancy.
//  - lotFull rising during OPEN does not revoke the open gate.
//  clearBlock: clears all strikes and laneBlocked next cycle; the FSM is untouched.
//    - If it coincides with a strike, clear wins.
//  Reset mid-operation: immediate return to reset values; occupancy is lost (by design).
// CONFIGURATION
//  PARKING_GRANT_TIMEOUT_EN defined:
//  - A counter runs in CHECK/OPEN. After TIMEOUT cycles in one grant, force IDLE and pulse grantTimeout.
//  - No strike, no occupancy change.
//  - Expiry in the same cycle as chkDone/laneEnter -> the event wins and the timeout is suppressed.
//  Undefined: no counter; grantTimeout tied 0; a grant may be held indefinitely.
// STRUCTURE
//  - parking_pkg.vh: FSM state encodings (IDLE/CHECK/OPEN), lane indices, default CAPACITY/MAX_TRIES.
//  - Sub-module parking_strike_counter (one per lane): inc/clr/clearAll inputs, blocked output at MAX_TRIES, saturating.
// TESTING
//  1. laneReq=01, pin0=8'h5A, chkDone&chkOk 3 cycles later, laneEnter=01
//     -> laneGnt=01 1 cycle after req; chkPin=5A; gateOpen=01; occupancy 0->1.
//  2. laneReq=11 held, both served OK
//     -> grants alternate lane0, lane1, lane0, with >= 1 IDLE cycle between grants.
//  3. lane1 three consecutive chkOk=0
//     -> laneBlocked=10 after the 3rd; lane1 req is ignored; clearBlock -> laneBlocked=00, strikes 0.
//  4. Fill to 16 via entries
//     -> lotFull=1, no grant on req; exitPulse -> occupancy 15, grant next IDLE.
//     -> exitPulse at 0 keeps 0; enter+exit in the same cycle keeps the count.
//  5. laneReq drops during CHECK; a late chkDone arrives
//     -> IDLE, no strike, no gate; assert rst_n low during OPEN -> all outputs 0 asynchronously.
//  6. With PARKING_GRANT_TIMEOUT_EN, TIMEOUT=8, no chkDone
//     -> grantTimeout pulses after 8 cycles in CHECK, laneGnt=0; without the macro the grant persists.

Source files
------------

// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared FSM encodings, lane indices and defaults for the parking lane arbiter
package parking_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CHECK = 2'd1,
      ST_OPEN  = 2'd2
   } park_state_t;

   localparam int LANE0 = 0;
   localparam int LANE1 = 1;

   localparam int DEF_CAPACITY  = 16;
   localparam int DEF_CNT_W     = 5;
   localparam int DEF_MAX_TRIES = 3;

   function automatic logic [1:0] lane_onehot(input logic idx);
      logic [1:0] oh;
      oh = 2'b00;
      oh[idx ? LANE1 : LANE0] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/parking_strike_counter.sv
// rtl/parking_strike_counter.sv - per-lane saturating bad-PIN counter with block flag
module parking_strike_counter
   import parking_pkg::*;
#(
   parameter int MAX_TRIES = DEF_MAX_TRIES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc,
   input  logic clr,
   input  logic clearAll,
   output logic blocked
);

   localparam int SW = $clog2(MAX_TRIES + 1);

   logic [SW-1:0] strikes;

   // Count consecutive bad PINs; operator clear and a good PIN both reset, clear beats a strike
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         strikes <= '0;
      end else if (clearAll || clr) begin
         strikes <= '0;
      end else if (inc && (strikes != SW'(MAX_TRIES))) begin
         strikes <= strikes + SW'(1);
      end
   end

   assign blocked = (strikes == SW'(MAX_TRIES));

endmodule

// File: rtl/parking_lane_arbiter.sv
// rtl/parking_lane_arbiter.sv - two-lane round-robin PIN/gate arbiter with lot occupancy (optional watchdog: PARKING_GRANT_TIMEOUT_EN)
module parking_lane_arbiter
   import parking_pkg::*;
#(
   parameter int CAPACITY  = DEF_CAPACITY,
   parameter int CNT_W     = DEF_CNT_W,
   parameter int MAX_TRIES = DEF_MAX_TRIES,
   parameter int TIMEOUT   = 255
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       laneReq,
   input  logic [7:0]       lanePin0,
   input  logic [7:0]       lanePin1,
   input  logic [1:0]       laneEnter,
   input  logic             exitPulse,
   input  logic             clearBlock,
   output logic             chkValid,
   output logic [7:0]       chkPin,
   input  logic             chkDone,
   input  logic             chkOk,
   output logic [1:0]       laneGnt,
   output logic [1:0]       gateOpen,
   output logic [1:0]       laneBlocked,
   output logic             lotFull,
   output logic [CNT_W-1:0] occupancy,
   output logic             grantTimeout
);

   park_state_t state, state_n;
   logic        last_served, last_n;
   logic [1:0]  gnt_n, gate_n;
   logic        valid_n;
   logic [7:0]  pin_n;
   logic [1:0]  eligible;
   logic        g;
   logic        sel;
   logic        leave;
   logic        occ_inc, occ_dec;
   logic [1:0]  strike_inc, strike_clr;
   logic        timer_hit;

   assign g        = laneGnt[LANE1];
   assign eligible = laneReq & ~laneBlocked;
   assign lotFull  = (occupancy == CNT_W'(CAPACITY));
   assign occ_dec  = exitPulse && (occupancy != '0);

   // Next-state and next-output decode; leaving a grant always clears grant/check/gate together
   always_comb begin
      state_n    = state;
      gnt_n      = laneGnt;
      valid_n    = chkValid;
      pin_n      = chkPin;
      gate_n     = gateOpen;
      last_n     = last_served;
      sel        = 1'b0;
      leave      = 1'b0;
      occ_inc    = 1'b0;
      strike_inc = 2'b00;
      strike_clr = 2'b00;
      case (state)
         ST_IDLE: begin
            sel = (eligible == 2'b11) ? ~last_served : eligible[LANE1];
            if (!lotFull && (eligible != 2'b00)) begin
               state_n = ST_CHECK;
               gnt_n   = lane_onehot(sel);
               valid_n = 1'b1;
               pin_n   = sel ? lanePin1 : lanePin0;
            end
         end
         ST_CHECK: begin
            if (!laneReq[g]) begin
               leave = 1'b1;
            end else if (chkDone) begin
               if (chkOk) begin
                  state_n       = ST_OPEN;
                  valid_n       = 1'b0;
                  gate_n        = laneGnt;
                  strike_clr[g] = 1'b1;
               end else begin
                  strike_inc[g] = 1'b1;
                  leave         = 1'b1;
               end
            end else if (timer_hit) begin
               leave = 1'b1;
            end
         end
         ST_OPEN: begin
            if (laneEnter[g]) begin
               occ_inc = 1'b1;
               leave   = 1'b1;
            end else if (!laneReq[g]) begin
               leave = 1'b1;
            end else if (timer_hit) begin
               leave = 1'b1;
            end
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase
      if (leave) begin
         state_n = ST_IDLE;
         gnt_n   = 2'b00;
         valid_n = 1'b0;
         gate_n  = 2'b00;
         last_n  = g;
      end
   end

   // FSM and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         laneGnt     <= 2'b00;
         chkValid    <= 1'b0;
         chkPin      <= 8'h00;
         gateOpen    <= 2'b00;
         last_served <= 1'b1;
      end else begin
         state       <= state_n;
         laneGnt     <= gnt_n;
         chkValid    <= valid_n;
         chkPin      <= pin_n;
         gateOpen    <= gate_n;
         last_served <= last_n;
      end
   end

   // Occupancy: simultaneous enter and exit cancel, never wraps below 0 or exceeds capacity
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occupancy <= '0;
      end else if (occ_inc && !occ_dec) begin
         if (occupancy != CNT_W'(CAPACITY)) begin
            occupancy <= occupancy + CNT_W'(1);
         end
      end else if (!occ_inc && occ_dec) begin
         occupancy <= occupancy - CNT_W'(1);
      end
   end

   for (genvar i = 0; i < 2; i++) begin : g_strike
      parking_strike_counter #(
         .MAX_TRIES (MAX_TRIES)
      ) u_strike (
         .clk      (clk),
         .rst_n    (rst_n),
         .inc      (strike_inc[i]),
         .clr      (strike_clr[i]),
         .clearAll (clearBlock),
         .blocked  (laneBlocked[i])
      );
   end

`ifdef PARKING_GRANT_TIMEOUT_EN
   localparam int TMR_W = $clog2(TIMEOUT + 1);

   logic [TMR_W-1:0] tmr;
   logic             grant_event;

   // A real grant event in the expiry cycle takes precedence over the watchdog
   always_comb begin
      grant_event = 1'b0;
      if (state == ST_CHECK) begin
         grant_event = chkDone || !laneReq[g];
      end else if (state == ST_OPEN) begin
         grant_event = laneEnter[g] || !laneReq[g];
      end
   end

   assign timer_hit = (state != ST_IDLE) && !grant_event && (tmr == TMR_W'(TIMEOUT - 1));

   // Cycles spent in the current grant, CHECK and OPEN combined
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmr <= '0;
      end else if ((state == ST_IDLE) || (state_n == ST_IDLE)) begin
         tmr <= '0;
      end else begin
         tmr <= tmr + TMR_W'(1);
      end
   end

   // One-cycle pulse on watchdog expiry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grantTimeout <= 1'b0;
      end else begin
         grantTimeout <= timer_hit;
      end
   end
`else
   assign timer_hit    = 1'b0;
   assign grantTimeout = 1'b0;
`endif

endmodule

// File: tb/tb_parking_lane_arbiter.sv
// tb/tb_parking_lane_arbiter.sv - directed scoreboard bench for parking_lane_arbiter
module tb_parking_lane_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] laneReq;
   logic [7:0] lanePin0, lanePin1;
   logic [1:0] laneEnter;
   logic       exitPulse, clearBlock;
   logic       chkValid;
   logic [7:0] chkPin;
   logic       chkDone, chkOk;
   logic [1:0] laneGnt, gateOpen, laneBlocked;
   logic       lotFull;
   logic [4:0] occupancy;
   logic       grantTimeout;

   typedef struct packed {
      logic [1:0] gnt;
      logic [7:0] pin;
   } exp_t;

   exp_t sb[$];
   int   n_assert = 0;
   int   n_fail   = 0;
   logic mdl_last;

   always #5 clk = ~clk;

   parking_lane_arbiter #(.TIMEOUT(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .laneReq      (laneReq),
      .lanePin0     (lanePin0),
      .lanePin1     (lanePin1),
      .laneEnter    (laneEnter),
      .exitPulse    (exitPulse),
      .clearBlock   (clearBlock),
      .chkValid     (chkValid),
      .chkPin       (chkPin),
      .chkDone      (chkDone),
      .chkOk        (chkOk),
      .laneGnt      (laneGnt),
      .gateOpen     (gateOpen),
      .laneBlocked  (laneBlocked),
      .lotFull      (lotFull),
      .occupancy    (occupancy),
      .grantTimeout (grantTimeout)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected grant for the lane picked by the round-robin model
   task automatic push_exp(input logic lane);
      exp_t e;
      e.gnt = lane ? 2'b10 : 2'b01;
      e.pin = lane ? lanePin1 : lanePin0;
      sb.push_back(e);
   endtask

   task automatic wait_grant(input string tag, output int lat);
      exp_t e;
      tick();
      lat = 1;
      while (laneGnt == 2'b00 && lat < 64) begin
         tick();
         lat++;
      end
      if (sb.size() == 0) begin
         chk({tag, "_sb_underflow"}, 32'(sb.size()), 32'd1);
      end else begin
         e = sb.pop_front();
         chk({tag, "_gnt"}, 32'(laneGnt), 32'(e.gnt));
         chk({tag, "_pin"}, 32'(chkPin), 32'(e.pin));
      end
   endtask

   task automatic pin_result(input logic ok);
      chkDone = 1'b1;
      chkOk   = ok;
      tick();
      chkDone = 1'b0;
      chkOk   = 1'b0;
   endtask

   initial begin
      int   lat;
      logic lane;
      rst_n = 1'b0; laneReq = 2'b00; lanePin0 = 8'h00; lanePin1 = 8'h00;
      laneEnter = 2'b00; exitPulse = 1'b0; clearBlock = 1'b0; chkDone = 1'b0; chkOk = 1'b0;
      mdl_last = 1'b1;
      tick();
      tick();
      chk("rst_gnt", 32'(laneGnt), 32'd0);
      chk("rst_valid", 32'(chkValid), 32'd0);
      chk("rst_gate", 32'(gateOpen), 32'd0);
      chk("rst_blocked", 32'(laneBlocked), 32'd0);
      chk("rst_occ", 32'(occupancy), 32'd0);
      chk("rst_full", 32'(lotFull), 32'd0);
      rst_n = 1'b1;
      tick();

      // 1: single lane0 transaction
      laneReq = 2'b01; lanePin0 = 8'h5A;
      push_exp(1'b0);
      wait_grant("t1", lat);
      chk("t1_latency", 32'(lat), 32'd1);
      chk("t1_valid", 32'(chkValid), 32'd1);
      tick(); tick();
      chk("t1_valid_held", 32'(chkValid), 32'd1);
      chk("t1_pin_held", 32'(chkPin), 32'h5A);
      pin_result(1'b1);
      chk("t1_gate", 32'(gateOpen), 32'd1);
      chk("t1_valid_drop", 32'(chkValid), 32'd0);
      laneEnter = 2'b01; laneReq = 2'b00;
      tick();
      laneEnter = 2'b00;
      chk("t1_occ", 32'(occupancy), 32'd1);
      chk("t1_gnt_off", 32'(laneGnt), 32'd0);
      mdl_last = 1'b0;

      // 2: both lanes requesting, round-robin from last served lane
      laneReq = 2'b11; lanePin0 = 8'h11; lanePin1 = 8'h22;
      for (int k = 0; k < 3; k++) begin
         lane = ~mdl_last;
         push_exp(lane);
         wait_grant("t2", lat);
         pin_result(1'b1);
         chk("t2_gate", 32'(gateOpen), 32'(lane ? 2'b10 : 2'b01));
         laneEnter = lane ? 2'b10 : 2'b01;
         tick();
         laneEnter = 2'b00;
         chk("t2_idle_gap", 32'(laneGnt), 32'd0);
         mdl_last = lane;
      end
      chk("t2_occ", 32'(occupancy), 32'd4);

      // 3: lane1 strikes out, then operator clear
      laneReq = 2'b10; lanePin1 = 8'hB1;
      for (int k = 0; k < 3; k++) begin
         push_exp(1'b1);
         wait_grant("t3", lat);
         pin_result(1'b0);
         chk("t3_gnt_off", 32'(laneGnt), 32'd0);
         chk("t3_blocked", 32'(laneBlocked), (k == 2) ? 32'd2 : 32'd0);
      end
      mdl_last = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("t3_blocked_nogrant", 32'(laneGnt), 32'd0);
      end
      laneReq = 2'b00; clearBlock = 1'b1;
      tick();
      clearBlock = 1'b0;
      chk("t3_cleared", 32'(laneBlocked), 32'd0);
      laneReq = 2'b10;
      for (int k = 0; k < 2; k++) begin
         push_exp(1'b1);
         wait_grant("t3b", lat);
         pin_result(1'b0);
         chk("t3b_not_blocked", 32'(laneBlocked), 32'd0);
      end
      push_exp(1'b1);
      wait_grant("t3c", lat);
      pin_result(1'b1);
      chk("t3c_gate", 32'(gateOpen), 32'd2);
      laneReq = 2'b00;
      tick();
      chk("t3c_gate_off", 32'(gateOpen), 32'd0);
      chk("t3c_no_count", 32'(occupancy), 32'd4);

      // 4: fill the lot, full refuses grants, exit frees a slot
      laneReq = 2'b01;
      for (int k = 0; k < 12; k++) begin
         lanePin0 = 8'h60 + 8'(k);
         push_exp(1'b0);
         wait_grant("t4", lat);
         pin_result(1'b1);
         laneEnter = 2'b01;
         tick();
         laneEnter = 2'b00;
      end
      mdl_last = 1'b0;
      chk("t4_occ_full", 32'(occupancy), 32'd16);
      chk("t4_lotfull", 32'(lotFull), 32'd1);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("t4_full_nogrant", 32'(laneGnt), 32'd0);
      end
      exitPulse = 1'b1;
      tick();
      exitPulse = 1'b0;
      chk("t4_occ_exit", 32'(occupancy), 32'd15);
      chk("t4_notfull", 32'(lotFull), 32'd0);
      push_exp(1'b0);
      wait_grant("t4_regrant", lat);
      chk("t4_regrant_lat", 32'(lat), 32'd1);

      // 5: abort during CHECK, late results ignored
      laneReq = 2'b00;
      tick();
      chk("t5_abort_gnt", 32'(laneGnt), 32'd0);
      chk("t5_abort_valid", 32'(chkValid), 32'd0);
      pin_result(1'b1);
      chk("t5_late_ok_gate", 32'(gateOpen), 32'd0);
      chk("t5_late_ok_gnt", 32'(laneGnt), 32'd0);
      for (int k = 0; k < 3; k++) pin_result(1'b0);
      chk("t5_late_bad_nostrike", 32'(laneBlocked), 32'd0);
      laneReq = 2'b01; lanePin0 = 8'h77;
      push_exp(1'b0);
      wait_grant("t5b", lat);
      pin_result(1'b1);
      laneEnter = 2'b10;
      tick();
      laneEnter = 2'b00;
      chk("t5_foreign_enter", 32'(occupancy), 32'd15);
      chk("t5_gate_kept", 32'(gateOpen), 32'd1);
      laneEnter = 2'b01; exitPulse = 1'b1; laneReq = 2'b00;
      tick();
      laneEnter = 2'b00; exitPulse = 1'b0;
      chk("t5_enter_exit_net0", 32'(occupancy), 32'd15);
      chk("t5_gate_closed", 32'(gateOpen), 32'd0);
      laneReq = 2'b01; lanePin0 = 8'h99;
      push_exp(1'b0);
      wait_grant("t5c", lat);
      pin_result(1'b1);
      chk("t5c_gate", 32'(gateOpen), 32'd1);
      #3 rst_n = 1'b0;
      #1;
      chk("t5_arst_gnt", 32'(laneGnt), 32'd0);
      chk("t5_arst_gate", 32'(gateOpen), 32'd0);
      chk("t5_arst_valid", 32'(chkValid), 32'd0);
      chk("t5_arst_pin", 32'(chkPin), 32'd0);
      chk("t5_arst_occ", 32'(occupancy), 32'd0);
      laneReq = 2'b00;
      tick();
      rst_n = 1'b1;
      mdl_last = 1'b1;
      exitPulse = 1'b1;
      tick();
      exitPulse = 1'b0;
      chk("t5_exit_at_zero", 32'(occupancy), 32'd0);

      // 6: grant held without a check result
      laneReq = 2'b01; lanePin0 = 8'hC3;
      push_exp(1'b0);
      wait_grant("t6", lat);
`ifdef PARKING_GRANT_TIMEOUT_EN
      for (int k = 0; k < 7; k++) begin
         tick();
         chk("t6_no_timeout_yet", 32'(grantTimeout), 32'd0);
         chk("t6_gnt_held", 32'(laneGnt), 32'd1);
      end
      tick();
      chk("t6_timeout_pulse", 32'(grantTimeout), 32'd1);
      chk("t6_gnt_revoked", 32'(laneGnt), 32'd0);
      laneReq = 2'b00;
      tick();
      chk("t6_pulse_end", 32'(grantTimeout), 32'd0);
`else
      for (int k = 0; k < 20; k++) tick();
      chk("t6_gnt_persists", 32'(laneGnt), 32'd1);
      chk("t6_no_timeout", 32'(grantTimeout), 32'd0);
      laneReq = 2'b00;
      tick();
      chk("t6_release", 32'(laneGnt), 32'd0);
`endif
      chk("t6_no_strike", 32'(laneBlocked), 32'd0);
      chk("t6_occ", 32'(occupancy), 32'd0);
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
